// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: MSB-first serial pattern transmitter with repeats; `define SEQ_TX_PREAMBLE_EN prefixes each frame with 1011
module seq_pattern_tx #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4,
    parameter int REP_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] pattern,
    input  logic [CNT_W-1:0]  nbits,
    input  logic [REP_W-1:0]  reps,
    output logic              out_bit,
    output logic              bit_valid,
    output logic              busy,
    output logic              done
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] PRE   = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] GAP   = 2'd3;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DATA_W);
`ifdef SEQ_TX_PREAMBLE_EN
    localparam logic [1:0] FIRST = PRE;
`else
    localparam logic [1:0] FIRST = SHIFT;
`endif
    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] pat_q, pat_d, sr_q, sr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, nb_q, nb_d;
    logic [REP_W-1:0]  rep_q, rep_d;
    logic              out_bit_q, out_bit_d, bit_valid_q, bit_valid_d;
    logic              busy_q, busy_d, done_q, done_d;
`ifdef SEQ_TX_PREAMBLE_EN
    logic [1:0]        pre_q, pre_d;
`endif
    // State and counters describe the bit being driven in the same cycle as they are held.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        nb_d    = nb_q;
        rep_d   = rep_q;
        done_d  = 1'b0;
`ifdef SEQ_TX_PREAMBLE_EN
        pre_d   = pre_q;
`endif
        case (state_q)
            IDLE: if (start) begin
                pat_d   = pattern;
                sr_d    = pattern;
                nb_d    = (nbits == '0 || nbits > FULL) ? FULL : nbits;
                rep_d   = reps;
                cnt_d   = CNT_W'(1);
                state_d = FIRST;
`ifdef SEQ_TX_PREAMBLE_EN
                pre_d   = 2'd0;
`endif
            end
`ifdef SEQ_TX_PREAMBLE_EN
            PRE: begin
                pre_d   = pre_q + 2'd1;
                state_d = (pre_q == 2'd3) ? SHIFT : PRE;
            end
`endif
            SHIFT: if (cnt_q == nb_q) begin
                state_d = (rep_q != '0) ? GAP : IDLE;
                done_d  = (rep_q == '0);
            end else begin
                sr_d  = sr_q << 1;
                cnt_d = cnt_q + CNT_W'(1);
            end
            GAP: begin
                sr_d    = pat_q;
                cnt_d   = CNT_W'(1);
                rep_d   = rep_q - REP_W'(1);
                state_d = FIRST;
`ifdef SEQ_TX_PREAMBLE_EN
                pre_d   = 2'd0;
`endif
            end
            default: state_d = IDLE;
        endcase
        bit_valid_d = (state_d == PRE) || (state_d == SHIFT);
        busy_d      = (state_d != IDLE);
`ifdef SEQ_TX_PREAMBLE_EN
        out_bit_d   = (state_d == SHIFT) ? sr_d[DATA_W-1] : (state_d == PRE) ? (pre_d != 2'd1) : 1'b0;
`else
        out_bit_d   = (state_d == SHIFT) & sr_d[DATA_W-1];
`endif
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pat_q       <= '0;
            sr_q        <= '0;
            cnt_q       <= '0;
            nb_q        <= '0;
            rep_q       <= '0;
            out_bit_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef SEQ_TX_PREAMBLE_EN
            pre_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            nb_q        <= nb_d;
            rep_q       <= rep_d;
            out_bit_q   <= out_bit_d;
            bit_valid_q <= bit_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef SEQ_TX_PREAMBLE_EN
            pre_q       <= pre_d;
`endif
        end
    end
    assign out_bit   = out_bit_q;
    assign bit_valid = bit_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx: table-driven check of seq_pattern_tx streams, repeats, ignored restarts and mid-frame reset
module tb_seq_pattern_tx;
    logic       clk = 1'b0;
    logic       reset, start;
    logic [7:0] pattern;
    logic [3:0] nbits, reps;
    logic       out_bit, bit_valid, busy, done;
    int         checks = 0;
    int         errors = 0;
`ifdef SEQ_TX_PREAMBLE_EN
    localparam bit PRE_EN = 1'b1;
`else
    localparam bit PRE_EN = 1'b0;
`endif
    typedef struct {
        logic [7:0]  pat;
        logic [3:0]  nb;
        logic [3:0]  reps;
        int          nexp;
        logic [15:0] exp;
        int          poke;
    } vec_t;
    vec_t vecs[7];
    seq_pattern_tx #(.DATA_W(8), .CNT_W(4), .REP_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .pattern(pattern), .nbits(nbits),
        .reps(reps), .out_bit(out_bit), .bit_valid(bit_valid), .busy(busy), .done(done)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0t: got %b want %b", name, $time, act, exp);
        end
    endtask
    task automatic launch(input vec_t v);
        start   = 1'b1;
        pattern = v.pat;
        nbits   = v.nb;
        reps    = v.reps;
        @(negedge clk);
        start   = 1'b0;
        pattern = ~v.pat;
        nbits   = 4'd1;
        reps    = 4'd7;
    endtask
    // Called at the negedge of the first expected bit; ends at the negedge after done (or of the chained start's first bit).
    task automatic follow(input vec_t v, input bit chain, input vec_t nv);
        bit eb[$];
        bit ev[$];
        for (int f = 0; f <= int'(v.reps); f++) begin
            if (f > 0) begin eb.push_back(1'b0); ev.push_back(1'b0); end
            if (PRE_EN) begin
                eb.push_back(1'b1); eb.push_back(1'b0); eb.push_back(1'b1); eb.push_back(1'b1);
                repeat (4) ev.push_back(1'b1);
            end
            for (int i = 0; i < v.nexp; i++) begin eb.push_back(v.exp[15-i]); ev.push_back(1'b1); end
        end
        for (int k = 0; k < eb.size(); k++) begin
            chk("out_bit", out_bit, eb[k]);
            chk("bit_valid", bit_valid, ev[k]);
            chk("busy", busy, 1'b1);
            chk("done_low", done, 1'b0);
            if (k == v.poke) begin start = 1'b1; pattern = 8'h00; nbits = 4'd3; end
            @(negedge clk);
            start = 1'b0;
        end
        chk("done_pulse", done, 1'b1);
        chk("busy_end", busy, 1'b0);
        chk("valid_end", bit_valid, 1'b0);
        chk("out_end", out_bit, 1'b0);
        if (chain) launch(nv);
        else begin
            @(negedge clk);
            chk("done_once", done, 1'b0);
            chk("busy_idle", busy, 1'b0);
        end
    endtask
    initial begin
        vecs[0] = '{8'hB0, 4'd4,  4'd0, 4, 16'hB000, -1};
        vecs[1] = '{8'hA5, 4'd8,  4'd0, 8, 16'hA500, -1};
        vecs[2] = '{8'hC0, 4'd2,  4'd2, 2, 16'hC000, -1};
        vecs[3] = '{8'h81, 4'd0,  4'd0, 8, 16'h8100, -1};
        vecs[4] = '{8'h81, 4'd15, 4'd0, 8, 16'h8100, -1};
        vecs[5] = '{8'h3C, 4'd9,  4'd1, 8, 16'h3C00, -1};
        vecs[6] = '{8'hFF, 4'd1,  4'd0, 1, 16'h8000, -1};
        reset = 1'b1; start = 1'b1; pattern = 8'hFF; nbits = 4'd0; reps = 4'd3;
        repeat (2) @(negedge clk);
        chk("rst_out", out_bit, 1'b0);
        chk("rst_valid", bit_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 1'b0);
        for (int i = 0; i < 7; i++) begin
            launch(vecs[i]);
            follow(vecs[i], 1'b0, vecs[i]);
        end
        begin
            vec_t v;
            v = vecs[1];
            v.poke = 2;
            launch(v);
            follow(v, 1'b0, v);
        end
        launch(vecs[6]);
        follow(vecs[6], 1'b1, vecs[0]);
        follow(vecs[0], 1'b0, vecs[0]);
        launch(vecs[1]);
        repeat (4) @(negedge clk);
        chk("pre_rst_valid", bit_valid, 1'b1);
        reset = 1'b1; start = 1'b1; pattern = 8'hFF;
        @(negedge clk);
        chk("midrst_out", out_bit, 1'b0);
        chk("midrst_valid", bit_valid, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        reset = 1'b0; start = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("post_rst_busy", busy, 1'b0);
            chk("post_rst_done", done, 1'b0);
        end
        launch(vecs[0]);
        follow(vecs[0], 1'b0, vecs[0]);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
